down_counter: RTL and testbench
===============================

Name: down_counter

Overview:
- Loadable down-counter/timer; the counting-down counterpart of the team's loadable up-counter.
- Loaded from a bus value, decrements on enable, saturates at zero, and flags terminal count with a one-cycle done pulse.
- Used as a timeout/delay generator beside the up-counter in memory/arithmetic datapaths.

Parameters:
- BUS_WIDTH, 8, width of load value and count output.

Ports:
- clk  input  1  single clock; all state changes on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- st  input  1  load strobe; sampled at posedge.
- X  input  BUS_WIDTH  load value, captured when st=1.
- en  input  1  count enable; decrement when high in RUN.
- o  output  BUS_WIDTH  current count, registered.
- busy  output  1  high while in RUN state, registered.
- zero  output  1  combinational (o == 0).
- done  output  1  registered one-cycle pulse at terminal count.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately without waiting for clk):
  - o=0, state=IDLE, busy=0, done=0, reload register=0; zero therefore reads 1.
  - Asserting reset mid-count aborts the count; no done pulse is produced.
- Registers update on posedge clk only while rst_n=1.
- FSM has two states, IDLE and RUN.
  - IDLE:
    - st=1 and X!=0 -> o<=X, go to RUN, busy<=1.
    - st=1 and X==0 -> o<=0, stay IDLE, no done pulse.
    - st=0 -> o holds; en is ignored.
  - RUN:
    - st=1 -> reload: o<=X; go to (or stay in) RUN if X!=0, else IDLE. st has priority over en and over terminal count.
    - st=0, en=0 -> hold o, stay RUN.
    - st=0, en=1, o>1 -> o<=o-1.
    - st=0, en=1, o==1 -> o<=0, done<=1, busy<=0, go to IDLE.
- done:
  - High for exactly one cycle, in the same cycle that o first reads 0 after a count.
  - Otherwise 0; cleared the following cycle.
- Arithmetic: unsigned BUS_WIDTH decrement.
  - Never wraps below zero; o never goes 0 -> all-ones.
  - X = all-ones (255 at default width) is a legal load.
- Latency:
  - Load visible on o one cycle after the st edge.
  - With en held high from the load cycle onward, done asserts N cycles after the loading edge for X=N.
- Simultaneous st=1 with terminal decrement: load wins; no done pulse.

Optional Feature:
- Macro: DOWN_COUNTER_AUTO_RELOAD_EN.
- Defined:
  - A reload register captures X on every st.
  - At terminal count (RUN, en=1, o==1), o<=reload, state stays RUN, busy stays 1, and done still pulses for one cycle.
  - The cycle o would read 0 is replaced by reload, so zero stays 0 during periodic operation.
  - Period = reload cycles when en is held high.
- Undefined:
  - No reload register is present; terminal count goes to IDLE as described above.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=1'b0, RUN=1'b1;
  - default BUS_WIDTH constant.
- One natural sub-module: decrement, a combinational BUS_WIDTH-bit minus-one. It is the counterpart of the existing increment, lives alongside it in the arithmetics modules, and is instantiated for the o-1 path.

Test Plan:
- Reset: drive rst_n=0 between clock edges mid-count (o=5) -> o=0, busy=0, done=0, zero=1 immediately, before the next posedge.
- Basic count: st=1, X=3, then en=1 continuously -> o sequence 3,2,1,0; done=1 only in the cycle o=0; busy falls the same cycle; o then holds 0 with no wrap.
- Pause: load X=4, en pattern 1,0,0,1,1,1 -> o 4,3,3,3,2,1,0; done exactly once, at 0.
- Zero load: st=1, X=0 -> o=0, state IDLE, busy=0, done never asserts. Also load X=255 with en high -> done after 255 cycles.
- Load collision: load X=2, en=1; in the cycle o=1 assert st=1, X=6 -> o=6, no done pulse, busy stays 1.
- Auto-reload (macro defined): load X=3, en=1 held -> o 3,2,1,3,2,1,...; done pulses every 3 cycles; busy stays 1. With macro undefined, same stimulus ends at o=0 in IDLE.

Source files
------------

// File: rtl/down_counter_pkg.sv
// Shared definitions for the loadable down-counter/timer: state encoding and default width.
// The auto-reload variant is selected with the DOWN_COUNTER_AUTO_RELOAD_EN macro.
package down_counter_pkg;

   localparam int DEFAULT_BUS_WIDTH = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/down_counter_decrement.sv
// Combinational minus-one, the counterpart of the increment in the arithmetic modules.
module down_counter_decrement #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y
);

   assign y = a - {{(WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/down_counter.sv
// Loadable down-counter/timer: loads X on st, decrements on en, saturates at zero, pulses done.
// Define DOWN_COUNTER_AUTO_RELOAD_EN to reload the last loaded value at terminal count instead of stopping.
module down_counter
   import down_counter_pkg::*;
#(
   parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 st,
   input  logic [BUS_WIDTH-1:0] X,
   input  logic                 en,
   output logic [BUS_WIDTH-1:0] o,
   output logic                 busy,
   output logic                 zero,
   output logic                 done
);

   localparam logic [BUS_WIDTH-1:0] ONE = {{(BUS_WIDTH-1){1'b0}}, 1'b1};

   // Handshake: st and en are level-sampled at posedge; st always wins over en and terminal count.
   state_t               state;
   logic [BUS_WIDTH-1:0] o_dec;
   logic                 load_nonzero;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
   logic [BUS_WIDTH-1:0] reload;
`endif

   down_counter_decrement #(
      .WIDTH(BUS_WIDTH)
   ) u_dec (
      .a(o),
      .y(o_dec)
   );

   assign load_nonzero = (X != '0);
   assign zero         = (o == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         o     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
         reload <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (st) begin
            o <= X;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload <= X;
`endif
            if (load_nonzero) begin
               state <= RUN;
               busy  <= 1'b1;
            end else begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         end else if (state == RUN && en) begin
            if (o == ONE) begin
               done <= 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
               // Reload is never zero while in RUN, so the period restarts cleanly.
               o <= reload;
`else
               o     <= '0;
               state <= IDLE;
               busy  <= 1'b0;
`endif
            end else if (o != '0) begin
               o <= o_dec;
            end
         end
      end
   end

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: random stimulus against an integer reference model plus directed checks.
module tb_down_counter;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         st;
   logic [W-1:0] X;
   logic         en;
   logic [W-1:0] o;
   logic         busy;
   logic         zero;
   logic         done;

   int n_cmp;
   int n_bad;

   int m_o;
   int m_busy;
   int m_done;
   int m_reload;

   down_counter #(.BUS_WIDTH(W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .st   (st),
      .X    (X),
      .en   (en),
      .o    (o),
      .busy (busy),
      .zero (zero),
      .done (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: a counter value in [0, 2^W), running while nonzero and loaded.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_o = 0; m_busy = 0; m_done = 0; m_reload = 0;
      end else begin
         m_done = 0;
         if (st) begin
            m_o      = int'(X);
            m_reload = int'(X);
            m_busy   = (m_o > 0) ? 1 : 0;
         end else if (m_busy == 1 && en) begin
            m_o = (m_o > 0) ? m_o - 1 : 0;
            if (m_o == 0) begin
               m_done = 1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
               m_o = m_reload;
`else
               m_busy = 0;
`endif
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("cyc_o", int'(o), m_o);
      chk("cyc_busy", int'(busy), m_busy);
      chk("cyc_done", int'(done), m_done);
      chk("cyc_zero", int'(zero), (m_o == 0) ? 1 : 0);
   end

   task automatic cycle(input logic st_v, input logic [W-1:0] x_v, input logic en_v);
      st = st_v;
      X  = x_v;
      en = en_v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int dones;
      int hit;
      logic [W-1:0] rx;
      n_cmp = 0;
      n_bad = 0;
      st = 1'b0; X = '0; en = 1'b0;
      rst_n = 1'b0;
      #12;
      chk("rst_o", int'(o), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_zero", int'(zero), 1);
      rst_n = 1'b1;
      cycle(0, 0, 0);

      // Basic count from 3 with en held high
      cycle(1, 3, 1);
      chk("basic_load", int'(o), 3);
      chk("basic_busy", int'(busy), 1);
      cycle(0, 0, 1);
      chk("basic_2", int'(o), 2);
      cycle(0, 0, 1);
      chk("basic_1", int'(o), 1);
      chk("basic_done_early", int'(done), 0);
      cycle(0, 0, 1);
      chk("basic_done", int'(done), 1);
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      chk("basic_term_o", int'(o), 3);
      chk("basic_term_busy", int'(busy), 1);
`else
      chk("basic_term_o", int'(o), 0);
      chk("basic_term_busy", int'(busy), 0);
      cycle(0, 0, 1);
      chk("basic_hold_o", int'(o), 0);
      chk("basic_done_clr", int'(done), 0);
`endif

      // Pause pattern after loading 4
      cycle(1, 4, 1);
      dones = 0;
      cycle(0, 0, 1); dones += int'(done);
      cycle(0, 0, 0); dones += int'(done);
      cycle(0, 0, 0); dones += int'(done);
      chk("pause_hold", int'(o), 3);
      cycle(0, 0, 1); dones += int'(done);
      cycle(0, 0, 1); dones += int'(done);
      cycle(0, 0, 1); dones += int'(done);
      chk("pause_dones", dones, 1);
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      chk("pause_end", int'(o), 4);
`else
      chk("pause_end", int'(o), 0);
`endif

      // Zero load stays idle with no done
      cycle(1, 0, 1);
      chk("zload_o", int'(o), 0);
      chk("zload_busy", int'(busy), 0);
      cycle(0, 0, 1);
      chk("zload_done", int'(done), 0);

      // Full-scale load: done exactly 255 edges after the load edge
      cycle(1, 8'hFF, 1);
      hit = 0;
      for (int i = 1; i <= 300 && hit == 0; i++) begin
         cycle(0, 0, 1);
         if (done) hit = i;
      end
      chk("full_latency", hit, 255);

      // Load collides with terminal decrement: load wins
      cycle(1, 2, 1);
      cycle(0, 0, 1);
      chk("coll_pre", int'(o), 1);
      cycle(1, 6, 1);
      chk("coll_o", int'(o), 6);
      chk("coll_done", int'(done), 0);
      chk("coll_busy", int'(busy), 1);

      // Periodic behaviour from 3
      cycle(1, 3, 1);
      dones = 0;
      for (int i = 0; i < 9; i++) begin
         cycle(0, 0, 1);
         dones += int'(done);
      end
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      chk("period_dones", dones, 3);
      chk("period_o", int'(o), 3);
      chk("period_busy", int'(busy), 1);
`else
      chk("period_dones", dones, 1);
      chk("period_o", int'(o), 0);
      chk("period_busy", int'(busy), 0);
`endif

      // Asynchronous reset mid-count at o=5
      cycle(1, 8, 1);
      cycle(0, 0, 1);
      cycle(0, 0, 1);
      cycle(0, 0, 1);
      chk("arst_pre", int'(o), 5);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_o", int'(o), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_done", int'(done), 0);
      chk("arst_zero", int'(zero), 1);
      st = 1'b0; en = 1'b1;
      @(posedge clk);
      #1;
      chk("arst_nodone", int'(done), 0);
      rst_n = 1'b1;
      cycle(0, 0, 1);

      // Random traffic, biased toward small loads so terminal counts are frequent
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 9))
            0:       rx = '0;
            1:       rx = 8'hFF;
            2:       rx = W'($urandom_range(0, 255));
            default: rx = W'($urandom_range(1, 6));
         endcase
         cycle(($urandom_range(0, 9) == 0), rx, ($urandom_range(0, 3) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
